// File: rtl/prime_sim.sv
// Prime-number benchmark engine: Sieve of Eratosthenes over an internal
// 1-bit table, followed by a count of the primes below N.
module prime_sim #(
  parameter int N  = 1000,
  parameter int AW = 10,
  parameter int CW = 16
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_run_req,
  output logic          o_run_busy,
  input  logic          i_start_req,
  output logic          o_start_busy,
  input  logic          i_join_req,
  output logic          o_join_busy,
  input  logic          i_yield_req,
  output logic          o_yield_busy,
  input  logic          i_finish_flag_in,
  input  logic          i_finish_flag_we,
  output logic          o_finish_flag_out,
  output logic [CW-1:0] o_prime_count_out,
  output logic [CW-1:0] o_last_prime_out
);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_OUTER, S_CHECK, S_MARK, S_COUNT, S_DONE
  } state_t;

  state_t          r_state;
  logic [AW-1:0]   r_i;
  logic [AW-1:0]   r_k;
  logic [AW:0]     r_j;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   r_last;
  logic [N-1:0]    r_table;

  logic [2*AW-1:0] w_isq;
  logic [AW-1:0]   w_addr;
  logic            w_we;
  logic            w_wdata;
  logic            w_rd;

  // i*i at double width so the outer-loop bound never overflows
  assign w_isq = (2*AW)'(r_i) * (2*AW)'(r_i);

  // Single table port: address/write-enable selected by the current state
  always_comb begin
    w_we    = 1'b0;
    w_wdata = 1'b0;
    w_addr  = r_k;
    case (r_state)
      S_INIT: begin
        w_we    = 1'b1;
        w_wdata = 1'b1;
        w_addr  = r_i;
      end
      S_CHECK: begin
        w_addr  = r_i;
      end
      S_MARK: begin
        w_we    = (r_j < (AW+1)'(N));
        w_addr  = r_j[AW-1:0];
      end
      default: begin
        w_addr  = r_k;
      end
    endcase
  end

  assign w_rd = r_table[w_addr];

  // Sieve table storage, contents undefined until INIT
  always_ff @(posedge i_clk) begin
    if (w_we) r_table[w_addr] <= w_wdata;
  end

  // Control FSM with registered status and result outputs
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state           <= S_IDLE;
      r_i               <= AW'(0);
      r_k               <= AW'(0);
      r_j               <= (AW+1)'(0);
      r_count           <= CW'(0);
      r_last            <= CW'(0);
      o_run_busy        <= 1'b0;
      o_start_busy      <= 1'b0;
      o_finish_flag_out <= 1'b0;
      o_prime_count_out <= CW'(0);
      o_last_prime_out  <= CW'(0);
    end else begin
      o_start_busy <= 1'b0;
      if (i_finish_flag_we) o_finish_flag_out <= i_finish_flag_in;
      case (r_state)
        S_IDLE: begin
          if (i_run_req | i_start_req) begin
            r_state      <= S_INIT;
            r_i          <= AW'(0);
            o_run_busy   <= 1'b1;
            o_start_busy <= i_start_req;
          end
        end
        S_INIT: begin
          if (r_i == AW'(N-1)) begin
            r_i     <= AW'(2);
            r_state <= S_OUTER;
          end else begin
            r_i     <= r_i + AW'(1);
          end
        end
        S_OUTER: begin
          if (w_isq >= (2*AW)'(N)) begin
            r_state <= S_COUNT;
            r_k     <= AW'(2);
            r_count <= CW'(0);
            r_last  <= CW'(0);
          end else begin
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (w_rd) begin
            r_j     <= (AW+1)'(w_isq);
            r_state <= S_MARK;
          end else begin
            r_i     <= r_i + AW'(1);
            r_state <= S_OUTER;
          end
        end
        S_MARK: begin
          if (r_j >= (AW+1)'(N)) begin
            r_i     <= r_i + AW'(1);
            r_state <= S_OUTER;
          end else begin
            r_j     <= r_j + (AW+1)'(r_i);
          end
        end
        S_COUNT: begin
          if (w_rd) begin
            r_count <= r_count + CW'(1);
            r_last  <= CW'(r_k);
          end
          if (r_k == AW'(N-1)) r_state <= S_DONE;
          else                 r_k     <= r_k + AW'(1);
        end
        S_DONE: begin
          o_prime_count_out <= r_count;
          o_last_prime_out  <= r_last;
          // completion wins over a simultaneous software write
          o_finish_flag_out <= 1'b1;
          o_run_busy        <= 1'b0;
          r_state           <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_join_busy  = i_join_req & o_run_busy;
  assign o_yield_busy = i_yield_req & 1'b0;

endmodule

// File: tb/tb_prime_sim.sv
// Bench for prime_sim: three instances (N=1000, 100, 4) checked against a
// trial-division reference and an event-level model of the control outputs.
module tb_prime_sim;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        rr[3], sr[3], jr[3], yr[3], fin[3], fwe[3];
  logic        rb[3], sb[3], jb[3], yb[3], ff[3];
  logic [15:0] cnt[3], lst[3];

  prime_sim #(.N(1000), .AW(10), .CW(16)) u_n1000 (
    .i_clk(clk), .i_reset(rst),
    .i_run_req(rr[0]), .o_run_busy(rb[0]), .i_start_req(sr[0]), .o_start_busy(sb[0]),
    .i_join_req(jr[0]), .o_join_busy(jb[0]), .i_yield_req(yr[0]), .o_yield_busy(yb[0]),
    .i_finish_flag_in(fin[0]), .i_finish_flag_we(fwe[0]), .o_finish_flag_out(ff[0]),
    .o_prime_count_out(cnt[0]), .o_last_prime_out(lst[0]));

  prime_sim #(.N(100), .AW(7), .CW(16)) u_n100 (
    .i_clk(clk), .i_reset(rst),
    .i_run_req(rr[1]), .o_run_busy(rb[1]), .i_start_req(sr[1]), .o_start_busy(sb[1]),
    .i_join_req(jr[1]), .o_join_busy(jb[1]), .i_yield_req(yr[1]), .o_yield_busy(yb[1]),
    .i_finish_flag_in(fin[1]), .i_finish_flag_we(fwe[1]), .o_finish_flag_out(ff[1]),
    .o_prime_count_out(cnt[1]), .o_last_prime_out(lst[1]));

  prime_sim #(.N(4), .AW(2), .CW(16)) u_n4 (
    .i_clk(clk), .i_reset(rst),
    .i_run_req(rr[2]), .o_run_busy(rb[2]), .i_start_req(sr[2]), .o_start_busy(sb[2]),
    .i_join_req(jr[2]), .o_join_busy(jb[2]), .i_yield_req(yr[2]), .o_yield_busy(yb[2]),
    .i_finish_flag_in(fin[2]), .i_finish_flag_we(fwe[2]), .o_finish_flag_out(ff[2]),
    .o_prime_count_out(cnt[2]), .o_last_prime_out(lst[2]));

  int total = 0;
  int bad   = 0;
  int ns[3] = '{1000, 100, 4};
  int mc[3], ml[3];
  logic e_ff[3];
  int   e_cnt[3], e_lst[3];
  logic p_rb[3] = '{1'b0, 1'b0, 1'b0};
  logic s_we[3], s_in[3], s_st[3], s_req[3];
  bit   rnd_on = 1'b0;

  task automatic chk(input string nm, input int u, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[u%0d] got=%0d want=%0d at %0t", nm, u, act, exp, $time);
    end
  endtask

  // reference: count primes below n by trial division
  function automatic void primes_below(input int n, output int c, output int l);
    c = 0;
    l = 0;
    for (int p = 2; p < n; p++) begin
      bit isp = 1'b1;
      for (int d = 2; d * d <= p; d++) if (p % d == 0) isp = 1'b0;
      if (isp) begin
        c++;
        l = p;
      end
    end
  endfunction

  // capture what each DUT sees at the active edge
  always @(posedge clk) begin
    for (int u = 0; u < 3; u++) begin
      s_we[u]  = fwe[u] & ~rst;
      s_in[u]  = fin[u];
      s_st[u]  = sr[u] & ~rst;
      s_req[u] = (rr[u] | sr[u]) & ~rst;
    end
  end

  // compare process: every cycle, every instance
  always @(negedge clk) begin
    for (int u = 0; u < 3; u++) begin
      if (rst) begin
        e_ff[u] = 1'b0; e_cnt[u] = 0; e_lst[u] = 0;
        chk("rst_run_busy", u, rb[u], 0);
        chk("rst_start_busy", u, sb[u], 0);
        chk("rst_finish", u, ff[u], 0);
        chk("rst_count", u, cnt[u], 0);
        chk("rst_last", u, lst[u], 0);
      end else begin
        if (p_rb[u] && !rb[u]) begin
          e_ff[u] = 1'b1; e_cnt[u] = mc[u]; e_lst[u] = ml[u];
        end else if (s_we[u]) begin
          e_ff[u] = s_in[u];
        end
        chk("finish_flag", u, ff[u], e_ff[u]);
        chk("prime_count", u, cnt[u], e_cnt[u]);
        chk("last_prime", u, lst[u], e_lst[u]);
        chk("start_busy", u, sb[u], (!p_rb[u] && rb[u] && s_st[u]));
        if (!p_rb[u] && rb[u]) chk("launch_needs_req", u, s_req[u], 1);
        chk("join_busy", u, jb[u], jr[u] & rb[u]);
        chk("yield_busy", u, yb[u], 0);
      end
      p_rb[u] = rb[u];
    end
  end

  // random side-band traffic on the small instances
  always @(negedge clk) begin
    if (rnd_on) begin
      #1;
      for (int u = 1; u < 3; u++) begin
        jr[u]  = 1'($urandom_range(0, 1));
        yr[u]  = 1'($urandom_range(0, 1));
        fwe[u] = ($urandom_range(0, 3) == 0);
        fin[u] = 1'($urandom_range(0, 1));
      end
    end
  end

  task automatic wait_done(input int u, input int budget, output int sbc);
    bit was, hit;
    int n;
    sbc = 0; hit = 1'b0; n = 0; was = rb[u];
    while (!hit && n < budget) begin
      @(negedge clk);
      n++;
      if (sb[u]) sbc++;
      if (was && !rb[u]) hit = 1'b1;
      was = rb[u];
    end
    chk("done_in_budget", u, hit, 1);
  endtask

  task automatic pulse_req(input int u, input bit use_start);
    #1;
    if (use_start) sr[u] = 1'b1; else rr[u] = 1'b1;
    @(negedge clk);
    #1;
    sr[u] = 1'b0; rr[u] = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, sbc;
    for (int u = 0; u < 3; u++) begin
      primes_below(ns[u], mc[u], ml[u]);
      rr[u] = 0; sr[u] = 0; jr[u] = 0; yr[u] = 0; fin[u] = 0; fwe[u] = 0;
    end
    chk("model_count_1000", 0, mc[0], 168);
    chk("model_last_1000", 0, ml[0], 997);
    chk("model_count_4", 2, mc[2], 2);

    repeat (4) @(negedge clk);
    #1 rst = 1'b0;
    repeat (20) @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      chk("idle_finish", u, ff[u], 0);
      chk("idle_busy", u, rb[u], 0);
    end

    // N=1000 with run_req tied high
    #1 rr[0] = 1'b1;
    n = 0;
    while (!rb[0] && n < 3) begin
      @(negedge clk);
      n++;
    end
    chk("busy_within_2", 0, (n <= 2) && rb[0], 1);
    wait_done(0, 20000, sbc);
    chk("n1000_finish", 0, ff[0], 1);
    chk("n1000_busy_low", 0, rb[0], 0);
    chk("n1000_count", 0, cnt[0], 168);
    chk("n1000_last", 0, lst[0], 997);
    @(negedge clk);
    chk("level_restart", 0, rb[0], 1);
    chk("finish_kept", 0, ff[0], 1);
    #1 rr[0] = 1'b0;

    // reset during the marking of multiples of 2
    repeat (1300) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_busy", 0, rb[0], 0);
    chk("async_rst_finish", 0, ff[0], 0);
    chk("async_rst_count", 0, cnt[0], 0);
    chk("async_rst_last", 0, lst[0], 0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0; rr[0] = 1'b1;
    @(negedge clk);
    wait_done(0, 20000, sbc);
    chk("rerun_count", 0, cnt[0], 168);
    chk("rerun_last", 0, lst[0], 997);
    #1 rr[0] = 1'b0;

    // N=100 launched by a start_req pulse with join held
    jr[1] = 1'b1; sr[1] = 1'b1;
    @(negedge clk);
    chk("start_busy_first", 1, sb[1], 1);
    chk("join_during_run", 1, jb[1], 1);
    #1 sr[1] = 1'b0;
    wait_done(1, 5000, sbc);
    chk("start_busy_once", 1, sbc, 0);
    chk("n100_count", 1, cnt[1], 25);
    chk("n100_last", 1, lst[1], 97);
    chk("join_drops", 1, jb[1], 0);
    chk("n100_finish", 1, ff[1], 1);
    #1 jr[1] = 1'b0;

    // N=4 smallest case
    pulse_req(2, 1'b0);
    wait_done(2, 1000, sbc);
    chk("n4_count", 2, cnt[2], 2);
    chk("n4_last", 2, lst[2], 3);

    // software writes to finish_flag
    #1 fwe[2] = 1'b1; fin[2] = 1'b0;
    @(negedge clk);
    chk("sw_clear", 2, ff[2], 0);
    #1 fin[2] = 1'b1;
    @(negedge clk);
    chk("sw_set", 2, ff[2], 1);
    #1 fin[2] = 1'b0;
    @(negedge clk);
    chk("sw_clear2", 2, ff[2], 0);

    // clear held across the whole run: completion still sets the flag
    pulse_req(2, 1'b0);
    wait_done(2, 1000, sbc);
    chk("done_beats_write", 2, ff[2], 1);
    #1 fwe[2] = 1'b0;

    // randomized launches with random side-band traffic
    rnd_on = 1'b1;
    for (int it = 0; it < 16; it++) begin
      int u;
      u = 1 + int'($urandom_range(0, 1));
      @(negedge clk);
      pulse_req(u, 1'($urandom_range(0, 1)));
      wait_done(u, 5000, sbc);
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end
    rnd_on = 1'b0;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
